reflet_pwm_gen: RTL and testbench



---
 rtl/reflet_pwm_gen_if.sv | 11 +
 rtl/reflet_pwm_gen.sv | 45 ++++
 tb/tb_reflet_pwm_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reflet_pwm_gen_if.sv
// PWM control/output bundle: period and duty from the register side, PWM line back.
interface reflet_pwm_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] duty_cycle;
  logic [WIDTH-1:0] max;
  logic             out;

  modport master (output duty_cycle, output max, input out);
  modport slave  (input duty_cycle, input max, output out);
endinterface

// File: rtl/reflet_pwm_gen.sv
// Free-running PWM generator; period and duty are shadowed and reloaded only at
// period boundaries so register writes never glitch the output.
module reflet_pwm_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  reflet_pwm_gen_if.slave    pwm
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_s_q, duty_s_d;
  logic [WIDTH-1:0] max_s_q, max_s_d;
  logic             period_end;

  // max_s == 0 forces a reload every edge, which also covers the first edge after reset.
  assign period_end = (max_s_q == '0) || (cnt_q >= max_s_q - WIDTH'(1));

  always_comb begin
    cnt_d    = cnt_q + WIDTH'(1);
    duty_s_d = duty_s_q;
    max_s_d  = max_s_q;
    if (period_end) begin
      cnt_d    = '0;
      duty_s_d = pwm.duty_cycle;
      max_s_d  = pwm.max;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      duty_s_q <= '0;
      max_s_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      duty_s_q <= duty_s_d;
      max_s_q  <= max_s_d;
    end
  end

  // Decoded from registered state only, so reset clears it without waiting for clk.
  assign pwm.out = (max_s_q != '0) && (cnt_q < duty_s_q);

endmodule

// File: tb/tb_reflet_pwm_gen.sv
// Directed and randomized bench for reflet_pwm_gen against a period-waveform model.
module tb_reflet_pwm_gen;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Expected output for each remaining cycle of the current period, front = now.
  bit   exp_q[$];

  reflet_pwm_gen_if #(.WIDTH(WIDTH)) pwm_if ();

  reflet_pwm_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pwm   (pwm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, expv, $time);
    end
  endtask

  // At a period start the whole waveform for that period is known from the sampled inputs.
  task automatic load_period();
    int unsigned mx;
    int unsigned du;
    int unsigned n;
    mx = int'(pwm_if.max);
    du = int'(pwm_if.duty_cycle);
    n  = (mx == 0) ? 1 : mx;
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back((mx != 0) && (i < du));
  endtask

  task automatic tick(input string tag);
    logic expv;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) load_period();
    end
    @(negedge clk);
    expv = (exp_q.size() != 0) ? exp_q[0] : 1'b0;
    check(tag, pwm_if.out, expv);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    pwm_if.duty_cycle = '0;
    pwm_if.max        = '0;

    // Reset held with clock toggling.
    for (int i = 0; i < 4; i++) begin
      tick("reset_out");
      check("reset_cnt", (dut.cnt_q == '0), 1'b1);
    end

    // max=10, duty=1.
    pwm_if.max        = 8'd10;
    pwm_if.duty_cycle = 8'd1;
    reset = 1'b1;
    run("m10_d1", 25);

    // duty 1->0 mid-period.
    pwm_if.duty_cycle = 8'd0;
    run("d1_to_0", 25);

    pwm_if.duty_cycle = 8'd3;
    run("d3", 22);
    pwm_if.duty_cycle = 8'd9;
    run("d9", 22);
    pwm_if.duty_cycle = 8'd10;
    run("d10", 22);
    pwm_if.duty_cycle = 8'd11;
    run("d11", 22);

    // max=0 then max=4, duty=2.
    pwm_if.max        = 8'd0;
    pwm_if.duty_cycle = 8'd5;
    run("max0", 15);
    pwm_if.max        = 8'd4;
    pwm_if.duty_cycle = 8'd2;
    run("m4_d2", 12);

    // max=1 boundary.
    pwm_if.max        = 8'd1;
    pwm_if.duty_cycle = 8'd1;
    run("m1_d1", 6);
    pwm_if.duty_cycle = 8'd0;
    run("m1_d0", 6);

    // Change-and-revert within one period has no effect.
    pwm_if.max        = 8'd12;
    pwm_if.duty_cycle = 8'd5;
    run("revert_pre", 14);
    pwm_if.duty_cycle = 8'd11;
    tick("revert_glitch");
    pwm_if.duty_cycle = 8'd5;
    run("revert_post", 20);

    // Reset pulsed during the high phase: out must fall before any clk edge.
    pwm_if.max        = 8'd8;
    pwm_if.duty_cycle = 8'd6;
    run("pre_rst", 20);
    while (exp_q.size() == 0 || exp_q[0] != 1'b1) tick("seek_high");
    check("high_before_rst", pwm_if.out, 1'b1);
    #2 reset = 1'b0;
    #1 check("async_rst_out", pwm_if.out, 1'b0);
    check("async_rst_cnt", (dut.cnt_q == '0), 1'b1);
    run("rst_hold", 3);
    reset = 1'b1;
    run("post_rst", 20);

    // Randomized inputs, including occasional short-lived changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        pwm_if.max        = WIDTH'($urandom_range(0, 12));
        pwm_if.duty_cycle = WIDTH'($urandom_range(0, 14));
      end
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the bench cannot hang.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
